move_arbiter: RTL and testbench
===============================

MOVE_ARBITER -- requirements
Module: move_arbiter

Interface
REQ-001 Parameter HOLDOFF_CYCLES, default 1000000, idle cycles enforced after an accepted move (10 ms at 100 MHz).
REQ-002 Parameter ACK_TIMEOUT, default 255, max cycles an offered move waits for move_ack.
REQ-003 CLK_100MHZ  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 mouse_square  in  9  clicked-square matrix from mouse decoder, one bit per square, 0 = no click.
REQ-006 btn_left, btn_right, btn_down, btn_center  in  1 each  debounced button levels.
REQ-007 occupied  in  9  squares already holding X or O.
REQ-008 game_active  in  1  high while a game accepts moves.
REQ-009 move_ack  in  1  single-cycle acceptance from game FSM.
REQ-010 move_valid  out  1  move offer to game FSM.
REQ-011 move_square  out  9  one-hot target, stable while move_valid high.
REQ-012 cursor  out  9  one-hot button-cursor position, for display highlight.
REQ-013 source  out  1  origin of current/last offer: 0 mouse, 1 buttons.
REQ-014 reject  out  1  single-cycle pulse when a request is refused.

Function
REQ-015 Button requests are rising edges of registered button levels; mouse request is a transition of mouse_square from zero (previous cycle) to nonzero.
REQ-016 Cursor index 0..8 (row-major), one-hot on cursor; btn_right edge: +1, 8 wraps to 0; btn_left edge: -1, 0 wraps to 8; btn_down edge: +3 mod 9 (6->0, 7->1, 8->2).
REQ-017 Cursor updates in every FSM state; simultaneous left and right edges cancel (no move); down combined with left/right applies down only.
REQ-018 btn_center edge is a button request targeting current cursor (value before any same-cycle cursor move).
REQ-019 FSM states IDLE, OFFER, HOLDOFF.
REQ-020 IDLE: request present and game_active=1 -> validate; request with game_active=0 -> discarded, no reject.
REQ-021 Same-cycle mouse and button requests: mouse wins, button request discarded silently.
REQ-022 Mouse request with more than one bit set -> reject pulse, stay IDLE.
REQ-023 Target bit set in occupied -> reject pulse, stay IDLE.
REQ-024 Valid target -> latch move_square and source, go OFFER; move_valid high the cycle after the request edge is sampled (1-cycle latency).
REQ-025 OFFER: move_valid=1, move_square held; move_ack=1 -> move_valid low next cycle, go HOLDOFF.
REQ-026 OFFER: ACK_TIMEOUT cycles without move_ack -> reject pulse, move_valid low, go IDLE.
REQ-027 OFFER: game_active falls -> move_valid low, go IDLE, no reject; move_ack same cycle takes priority (go HOLDOFF).
REQ-028 HOLDOFF: counts HOLDOFF_CYCLES cycles, then IDLE; counter restarts on every HOLDOFF entry.
REQ-029 Requests arriving in OFFER or HOLDOFF are discarded, never queued, no reject.
REQ-030 move_ack while in IDLE or HOLDOFF is ignored.
REQ-031 Counters sized ceil(log2(param+1)) bits; no wrap before terminal count.

Reset
REQ-032 On reset: state IDLE, move_valid 0, move_square 0, cursor 9'b000010000 (index 4), source 0, reject 0, counters 0, edge-detect history registers 0.
REQ-033 Reset mid-OFFER drops move_valid asynchronously; a button held high through reset release produces no edge.

Verification (HOLDOFF_CYCLES=4, ACK_TIMEOUT=8)
REQ-034 Reset, 3x btn_right edges -> cursor index 7 (9'b010000000); btn_down -> index 1; 2x btn_left -> index 8.
REQ-035 game_active=1, occupied=0, mouse_square 0->9'b000000100 -> next cycle move_valid=1, move_square=9'b000000100, source=0; ack -> HOLDOFF, further click within 4 cycles ignored.
REQ-036 Cursor 4, occupied=9'b000010000, btn_center -> reject one cycle, move_valid stays 0.
REQ-037 Same cycle mouse 9'b000000001 and btn_center (cursor 4) -> move_square=9'b000000001, source=0.
REQ-038 Offer with no ack for 8 cycles -> reject pulse, move_valid 0, IDLE; mouse_square=9'b000000011 -> reject.
REQ-039 Assert reset during OFFER -> move_valid 0 immediately, cursor index 4 after release.

Source files
------------

// File: rtl/move_arbiter.sv
// move_arbiter
//   Merges move requests from the mouse decoder and the button cursor into a
//   single one-hot move offer for the game FSM. It also enforces an ack
//   timeout on each offer and a hold-off window after every accepted move.
//
// Ports
//   i_clk_100mhz    sole clock, rising edge
//   i_reset         asynchronous active-high reset
//   i_mouse_square  clicked-square matrix (0 = no click)
//   i_btn_left/right/down/center  debounced button levels
//   i_occupied      squares already holding X or O
//   i_game_active   high while the game accepts moves
//   i_move_ack      single-cycle acceptance from the game FSM
//   o_move_valid    move offer
//   o_move_square   one-hot target, stable while o_move_valid is high
//   o_cursor        one-hot button cursor position
//   o_source        origin of the current/last offer (0 mouse, 1 buttons)
//   o_reject        single-cycle pulse when a request is refused
//
// state      | meaning
// ST_IDLE    | waiting for a mouse click or a centre press
// ST_OFFER   | move_valid high, waiting for move_ack (bounded by ACK_TIMEOUT)
// ST_HOLDOFF | ignoring requests for HOLDOFF_CYCLES after an accepted move
module move_arbiter #(
  parameter int HOLDOFF_CYCLES = 1000000,
  parameter int ACK_TIMEOUT    = 255
) (
  input  logic       i_clk_100mhz,
  input  logic       i_reset,
  input  logic [8:0] i_mouse_square,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_btn_down,
  input  logic       i_btn_center,
  input  logic [8:0] i_occupied,
  input  logic       i_game_active,
  input  logic       i_move_ack,
  output logic       o_move_valid,
  output logic [8:0] o_move_square,
  output logic [8:0] o_cursor,
  output logic       o_source,
  output logic       o_reject
);

  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [AW-1:0] ACK_LOAD  = AW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_OFFER, ST_HOLDOFF} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_armed;
  logic            r_btn_l_d, r_btn_r_d, r_btn_dn_d, r_btn_c_d, r_mouse_nz_d;
  logic [3:0]      r_cur_idx;
  logic [3:0]      w_idx_nxt;
  logic [8:0]      r_move_square;
  logic            r_source;
  logic            r_reject;
  logic [AW-1:0]   r_ack_cnt;
  logic [HW-1:0]   r_hold_cnt;

  logic            w_edge_l, w_edge_r, w_edge_dn, w_edge_c;
  logic            w_mouse_nz, w_mouse_req, w_mouse_onehot;
  logic [8:0]      w_cursor_oh;
  logic            w_take, w_take_src, w_reject_nxt;
  logic [8:0]      w_take_sq;

  // r_armed stays low for the first cycle after reset so a level already high
  // at reset release only loads the history and never counts as an edge.
  assign w_edge_l    = r_armed & i_btn_left   & ~r_btn_l_d;
  assign w_edge_r    = r_armed & i_btn_right  & ~r_btn_r_d;
  assign w_edge_dn   = r_armed & i_btn_down   & ~r_btn_dn_d;
  assign w_edge_c    = r_armed & i_btn_center & ~r_btn_c_d;
  assign w_mouse_nz  = |i_mouse_square;
  assign w_mouse_req = r_armed & w_mouse_nz & ~r_mouse_nz_d;
  assign w_mouse_onehot = w_mouse_nz & ~|(i_mouse_square & (i_mouse_square - 9'd1));
  assign w_cursor_oh = 9'd1 << r_cur_idx;

  always_comb begin
    w_idx_nxt = r_cur_idx;
    if (w_edge_dn)
      w_idx_nxt = (r_cur_idx >= 4'd6) ? r_cur_idx - 4'd6 : r_cur_idx + 4'd3;
    else if (w_edge_r && !w_edge_l)
      w_idx_nxt = (r_cur_idx == 4'd8) ? 4'd0 : r_cur_idx + 4'd1;
    else if (w_edge_l && !w_edge_r)
      w_idx_nxt = (r_cur_idx == 4'd0) ? 4'd8 : r_cur_idx - 4'd1;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_reject_nxt = 1'b0;
    w_take       = 1'b0;
    w_take_sq    = '0;
    w_take_src   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_game_active) begin
          // a mouse click shadows a same-cycle centre press
          if (w_mouse_req) begin
            if (!w_mouse_onehot || |(i_mouse_square & i_occupied)) begin
              w_reject_nxt = 1'b1;
            end else begin
              w_take    = 1'b1;
              w_take_sq = i_mouse_square;
            end
          end else if (w_edge_c) begin
            if (|(w_cursor_oh & i_occupied)) begin
              w_reject_nxt = 1'b1;
            end else begin
              w_take     = 1'b1;
              w_take_sq  = w_cursor_oh;
              w_take_src = 1'b1;
            end
          end
        end
        if (w_take) w_state_nxt = ST_OFFER;
      end
      ST_OFFER: begin
        if (i_move_ack) begin
          w_state_nxt = ST_HOLDOFF;
        end else if (!i_game_active) begin
          w_state_nxt = ST_IDLE;
        end else if (r_ack_cnt == '0) begin
          w_state_nxt  = ST_IDLE;
          w_reject_nxt = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (r_hold_cnt == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_100mhz or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_armed       <= 1'b0;
      r_btn_l_d     <= 1'b0;
      r_btn_r_d     <= 1'b0;
      r_btn_dn_d    <= 1'b0;
      r_btn_c_d     <= 1'b0;
      r_mouse_nz_d  <= 1'b0;
      r_cur_idx     <= 4'd4;
      r_move_square <= '0;
      r_source      <= 1'b0;
      r_reject      <= 1'b0;
      r_ack_cnt     <= '0;
      r_hold_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_armed      <= 1'b1;
      r_btn_l_d    <= i_btn_left;
      r_btn_r_d    <= i_btn_right;
      r_btn_dn_d   <= i_btn_down;
      r_btn_c_d    <= i_btn_center;
      r_mouse_nz_d <= w_mouse_nz;
      r_cur_idx    <= w_idx_nxt;
      r_reject     <= w_reject_nxt;
      if (w_take) begin
        r_move_square <= w_take_sq;
        r_source      <= w_take_src;
      end
      // loaded with N-1 so the terminal count falls on the Nth cycle
      if (w_take)
        r_ack_cnt <= ACK_LOAD;
      else if (r_state == ST_OFFER && r_ack_cnt != '0)
        r_ack_cnt <= r_ack_cnt - 1'b1;
      if (r_state == ST_OFFER && w_state_nxt == ST_HOLDOFF)
        r_hold_cnt <= HOLD_LOAD;
      else if (r_state == ST_HOLDOFF && r_hold_cnt != '0)
        r_hold_cnt <= r_hold_cnt - 1'b1;
    end
  end

  // decoded from the state register so reset removes the offer immediately
  assign o_move_valid  = (r_state == ST_OFFER);
  assign o_move_square = r_move_square;
  assign o_cursor      = w_cursor_oh;
  assign o_source      = r_source;
  assign o_reject      = r_reject;

endmodule

// File: tb/tb_move_arbiter.sv
// tb_move_arbiter
//   Directed bench for move_arbiter (HOLDOFF_CYCLES=4, ACK_TIMEOUT=8). A
//   cycle-level reference model tracks cursor, mode and offer age; a compare
//   process checks every output after each rising edge; literal checks pin
//   the expected behaviour of key scenarios.
module tb_move_arbiter;

  localparam int HOLD   = 4;
  localparam int ACK_TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] mouse = '0;
  logic       btn_l = 1'b0, btn_r = 1'b0, btn_d = 1'b0, btn_c = 1'b0;
  logic [8:0] occ = '0;
  logic       ga = 1'b0;
  logic       ack = 1'b0;
  logic       move_valid;
  logic [8:0] move_square;
  logic [8:0] cursor;
  logic       source;
  logic       reject;

  int n_checks = 0;
  int n_errors = 0;

  move_arbiter #(.HOLDOFF_CYCLES(HOLD), .ACK_TIMEOUT(ACK_TO)) dut (
    .i_clk_100mhz  (clk),
    .i_reset       (rst),
    .i_mouse_square(mouse),
    .i_btn_left    (btn_l),
    .i_btn_right   (btn_r),
    .i_btn_down    (btn_d),
    .i_btn_center  (btn_c),
    .i_occupied    (occ),
    .i_game_active (ga),
    .i_move_ack    (ack),
    .o_move_valid  (move_valid),
    .o_move_square (move_square),
    .o_cursor      (cursor),
    .o_source      (source),
    .o_reject      (reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: mode 0 idle, 1 offering, 2 hold-off; m_age counts
  // cycles spent in the current offer or hold-off
  int         m_mode = 0;
  int         m_cur  = 4;
  int         m_age  = 0;
  logic [8:0] m_sq   = '0;
  bit         m_src = 0, m_rej = 0, m_armed = 0;
  bit         p_l = 0, p_r = 0, p_d = 0, p_c = 0, p_m = 0;

  task automatic model_step();
    bit el, er, ed, ec, mreq;
    logic [8:0] tgt;
    el   = m_armed && btn_l && !p_l;
    er   = m_armed && btn_r && !p_r;
    ed   = m_armed && btn_d && !p_d;
    ec   = m_armed && btn_c && !p_c;
    mreq = m_armed && (mouse != 0) && !p_m;
    tgt  = 9'd1 << m_cur;
    m_rej = 0;
    if (ed) m_cur = (m_cur + 3) % 9;
    else if (er && !el) m_cur = (m_cur + 1) % 9;
    else if (el && !er) m_cur = (m_cur + 8) % 9;
    case (m_mode)
      0: if (ga) begin
        if (mreq) begin
          if ($countones(mouse) != 1 || (mouse & occ) != 0) m_rej = 1;
          else begin m_mode = 1; m_sq = mouse; m_src = 0; m_age = 0; end
        end else if (ec) begin
          if ((tgt & occ) != 0) m_rej = 1;
          else begin m_mode = 1; m_sq = tgt; m_src = 1; m_age = 0; end
        end
      end
      1: begin
        m_age++;
        if (ack) begin m_mode = 2; m_age = 0; end
        else if (!ga) m_mode = 0;
        else if (m_age >= ACK_TO) begin m_rej = 1; m_mode = 0; end
      end
      default: begin
        m_age++;
        if (m_age >= HOLD) m_mode = 0;
      end
    endcase
    p_l = btn_l; p_r = btn_r; p_d = btn_d; p_c = btn_c; p_m = (mouse != 0);
    m_armed = 1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_cur = 4; m_age = 0; m_sq = '0; m_src = 0; m_rej = 0;
      m_armed = 0; p_l = 0; p_r = 0; p_d = 0; p_c = 0; p_m = 0;
    end else begin
      model_step();
    end
  end

  always @(posedge clk) begin
    #1;
    chk("model move_valid", {8'd0, move_valid}, {8'd0, m_mode == 1});
    chk("model move_square", move_square, m_sq);
    chk("model cursor", cursor, 9'd1 << m_cur);
    chk("model source", {8'd0, source}, {8'd0, m_src});
    chk("model reject", {8'd0, reject}, {8'd0, m_rej});
  end

  task automatic press(input int which);
    @(negedge clk);
    case (which)
      0: btn_l = 1'b1;
      1: btn_r = 1'b1;
      2: btn_d = 1'b1;
      default: btn_c = 1'b1;
    endcase
    @(negedge clk);
    btn_l = 1'b0; btn_r = 1'b0; btn_d = 1'b0; btn_c = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset cursor", cursor, 9'b000010000);
    chk("reset valid", {8'd0, move_valid}, 9'd0);
    chk("reset square", move_square, 9'd0);
    chk("reset reject", {8'd0, reject}, 9'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // cursor movement
    repeat (3) press(1);
    chk("cursor 3x right", cursor, 9'b010000000);
    press(2);
    chk("cursor down 7->1", cursor, 9'b000000010);
    repeat (2) press(0);
    chk("cursor 2x left wrap", cursor, 9'b100000000);
    @(negedge clk); btn_l = 1'b1; btn_r = 1'b1;
    @(negedge clk); btn_l = 1'b0; btn_r = 1'b0;
    chk("left+right cancel", cursor, 9'b100000000);
    @(negedge clk); btn_d = 1'b1; btn_r = 1'b1;
    @(negedge clk); btn_d = 1'b0; btn_r = 1'b0;
    chk("down+right 8->2", cursor, 9'b000000100);

    // mouse offer, ack, click during hold-off
    ga = 1'b1;
    @(negedge clk); mouse = 9'b000000100;
    @(posedge clk); #1;
    chk("mouse offer valid", {8'd0, move_valid}, 9'd1);
    chk("mouse offer square", move_square, 9'b000000100);
    chk("mouse offer source", {8'd0, source}, 9'd0);
    @(negedge clk); mouse = '0; ack = 1'b1;
    @(negedge clk); ack = 1'b0; mouse = 9'b000001000;
    chk("after ack valid", {8'd0, move_valid}, 9'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mouse = '0;
      chk("holdoff ignores click", {8'd0, move_valid}, 9'd0);
    end
    repeat (3) @(negedge clk);

    // centre press on an occupied square
    repeat (2) press(1);
    chk("cursor back to 4", cursor, 9'b000010000);
    @(negedge clk); occ = 9'b000010000; btn_c = 1'b1;
    @(posedge clk); #1;
    chk("occupied reject", {8'd0, reject}, 9'd1);
    chk("occupied no offer", {8'd0, move_valid}, 9'd0);
    @(negedge clk); btn_c = 1'b0;
    @(posedge clk); #1;
    chk("reject one cycle", {8'd0, reject}, 9'd0);
    @(negedge clk); occ = '0;

    // mouse beats same-cycle centre press
    @(negedge clk); mouse = 9'b000000001; btn_c = 1'b1;
    @(posedge clk); #1;
    chk("mouse wins square", move_square, 9'b000000001);
    chk("mouse wins source", {8'd0, source}, 9'd0);
    @(negedge clk); mouse = '0; btn_c = 1'b0; ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    repeat (6) @(negedge clk);

    // button offer then ack timeout
    @(negedge clk); btn_c = 1'b1;
    @(posedge clk); #1;
    chk("button offer square", move_square, 9'b000010000);
    chk("button offer source", {8'd0, source}, 9'd1);
    @(negedge clk); btn_c = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("offer held 8th cycle", {8'd0, move_valid}, 9'd1);
    @(posedge clk); #1;
    chk("timeout valid low", {8'd0, move_valid}, 9'd0);
    chk("timeout reject", {8'd0, reject}, 9'd1);
    @(negedge clk); mouse = 9'b000000011;
    @(posedge clk); #1;
    chk("multi-bit reject", {8'd0, reject}, 9'd1);
    chk("multi-bit no offer", {8'd0, move_valid}, 9'd0);
    @(negedge clk); mouse = '0;

    // game_active falls during an offer
    @(negedge clk); mouse = 9'b000100000;
    @(negedge clk); mouse = '0; ga = 1'b0;
    @(posedge clk); #1;
    chk("ga drop valid low", {8'd0, move_valid}, 9'd0);
    chk("ga drop no reject", {8'd0, reject}, 9'd0);
    @(negedge clk); ga = 1'b1;
    // ack wins over game_active falling, then a click in hold-off
    @(negedge clk); mouse = 9'b001000000;
    @(negedge clk); mouse = '0; ga = 1'b0; ack = 1'b1;
    @(negedge clk); ack = 1'b0; ga = 1'b1; mouse = 9'b010000000;
    @(negedge clk); mouse = '0;
    repeat (5) @(negedge clk);
    // request while game inactive, stray ack in idle
    ga = 1'b0; mouse = 9'b100000000;
    @(negedge clk); mouse = '0; ga = 1'b1; ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    @(negedge clk);

    // reset during an offer, right button held through release
    @(negedge clk); mouse = 9'b000000010;
    @(posedge clk); #1;
    chk("pre-reset offer", {8'd0, move_valid}, 9'd1);
    #3 rst = 1'b1; btn_r = 1'b1;
    #1 chk("async reset drops valid", {8'd0, move_valid}, 9'd0);
    @(negedge clk); mouse = '0;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("held button no edge", cursor, 9'b000010000);
    btn_r = 1'b0;
    press(1);
    chk("edge after release", cursor, 9'b000100000);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
